// File: rtl/interp_ring8_pipe.sv
`timescale 1ns/1ps
// interp_ring8_pipe
// Eight-neighbour circular ring sampler for the LBP feature path. Each
// accepted beat carries four cardinal samples and four 2x2 corner groups;
// the block emits eight unsigned 8.FRAC ring samples. Cardinal slots are the
// sample padded with FRAC zero bits. Diagonal slots are either the bilinear
// blend wA*A + wBC*(B+C) + wD*D (MODE=1) or the nearer of corners A/D
// (MODE=0).
//
// Register stages (all advance together on en = ready_i | ~valid_o):
//   S1 input capture -> S2 weighted products -> S3 sums -> output register.
//   A beat accepted at edge n is presented with valid_o=1 after edge n+3.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous reset, active low
//   valid_i/ready_o  input handshake (ready_o is combinational)
//   card_i           cardinal bytes 0/90/180/270 degrees, LSB first
//   diag_i           four 32-bit corner groups (45/135/225/315), bytes A,B,C,D
//   done_i           frame-done flag, travels with the accepted beat
//   progress_done_i  progress flag, travels with the accepted beat
//   s_o              eight (8+FRAC)-bit slots, slot k = direction k*45 degrees
//   valid_o/ready_i  output handshake
//   done_o           frame-done flag of the beat on s_o
//   progress_done_o  progress flag of the beat on s_o
module interp_ring8_pipe #(
    parameter int R    = 2,
    parameter int FRAC = 16,
    parameter int MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [31:0]           card_i,
    input  logic [127:0]          diag_i,
    input  logic                  done_i,
    input  logic                  progress_done_i,
    output logic [8*(8+FRAC)-1:0] s_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  done_o,
    output logic                  progress_done_o
);

    localparam int OW = 8 + FRAC;

    // Q16 weight table; idx 0 = wA, 1 = wBC, 2 = wD.
    function automatic int w16_of(input int r, input int idx);
        int w;
        case (r * 32'sd4 + idx)
            32'sd4:  w = 32'sd5622;
            32'sd5:  w = 32'sd13573;
            32'sd6:  w = 32'sd32768;
            32'sd8:  w = 32'sd22488;
            32'sd9:  w = 32'sd15902;
            32'sd10: w = 32'sd11244;
            32'sd12: w = 32'sd50599;
            32'sd13: w = 32'sd6986;
            32'sd14: w = 32'sd965;
            32'sd16: w = 32'sd1929;
            32'sd17: w = 32'sd9315;
            32'sd18: w = 32'sd44977;
            default: w = 32'sd0;
        endcase
        return w;
    endfunction

    // Round-half-up rescale of a Q16 weight down to Q(16-sh).
    function automatic int rescale(input int w, input int sh);
        int v;
        int half;
        if (sh == 32'sd0) begin
            v = w;
        end else begin
            half = 32'sd1 <<< (sh - 32'sd1);
            v = (w + half) >>> sh;
        end
        return v;
    endfunction

    // wA absorbs the rounding so the three weights always sum to 2^FRAC,
    // which keeps the blend exact and inside 8+FRAC bits.
    localparam int WBC_I = rescale(w16_of(R, 32'sd1), 32'sd16 - FRAC);
    localparam int WD_I  = rescale(w16_of(R, 32'sd2), 32'sd16 - FRAC);
    localparam int WA_I  = (32'sd1 <<< FRAC) - 32'sd2 * WBC_I - WD_I;

    localparam logic [OW-1:0] WA  = OW'(WA_I);
    localparam logic [OW-1:0] WBC = OW'(WBC_I);
    localparam logic [OW-1:0] WD  = OW'(WD_I);

    // Nearest mode picks the far corner when it carries at least half weight.
    localparam bit NEAR_D = (WD_I >= (32'sd1 <<< (FRAC - 32'sd1)));

    if (R < 1 || R > 4) begin : g_bad_r
        $error("interp_ring8_pipe: R must be 1..4");
    end
    if (FRAC < 8 || FRAC > 16) begin : g_bad_frac
        $error("interp_ring8_pipe: FRAC must be 8..16");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("interp_ring8_pipe: MODE must be 0 or 1");
    end

    logic            en;
    logic            v1, v2, v3;
    logic [31:0]     card1, card2, card3;
    logic [127:0]    diag1;
    logic            d1, p1, d2, p2, d3, p3;
    logic [OW-1:0]   pa_n  [4];
    logic [OW-1:0]   pbc_n [4];
    logic [OW-1:0]   pd_n  [4];
    logic [OW-1:0]   pa2   [4];
    logic [OW-1:0]   pbc2  [4];
    logic [OW-1:0]   pd2   [4];
    logic [OW-1:0]   sum_n [4];
    logic [OW-1:0]   sum3  [4];
    logic [8*OW-1:0] s_n;

    // The whole pipe moves whenever the output slot is free or being taken.
    assign en      = ready_i | ~valid_o;
    assign ready_o = en;

    // S1: capture the beat; flags are gated so bubbles never carry a flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1    <= 1'b0;
            card1 <= 32'd0;
            diag1 <= 128'd0;
            d1    <= 1'b0;
            p1    <= 1'b0;
        end else if (en) begin
            v1    <= valid_i;
            card1 <= card_i;
            diag1 <= diag_i;
            d1    <= valid_i & done_i;
            p1    <= valid_i & progress_done_i;
        end
    end

    // Weighted corner products (or the nearest corner, pre-shifted).
    always_comb begin
        pa_n  = '{default: '0};
        pbc_n = '{default: '0};
        pd_n  = '{default: '0};
        for (int g = 0; g < 4; g++) begin
            if (MODE != 0) begin
                pa_n[g]  = WA * OW'(diag1[g*32 +: 8]);
                pbc_n[g] = WBC * (OW'(diag1[g*32+8 +: 8]) + OW'(diag1[g*32+16 +: 8]));
                pd_n[g]  = WD * OW'(diag1[g*32+24 +: 8]);
            end else begin
                pa_n[g]  = {(NEAR_D ? diag1[g*32+24 +: 8] : diag1[g*32 +: 8]), {FRAC{1'b0}}};
                pbc_n[g] = '0;
                pd_n[g]  = '0;
            end
        end
    end

    // S2: product registers plus cardinal/flag delay.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v2    <= 1'b0;
            card2 <= 32'd0;
            d2    <= 1'b0;
            p2    <= 1'b0;
            for (int g = 0; g < 4; g++) begin
                pa2[g]  <= '0;
                pbc2[g] <= '0;
                pd2[g]  <= '0;
            end
        end else if (en) begin
            v2    <= v1;
            card2 <= card1;
            d2    <= d1;
            p2    <= p1;
            pa2   <= pa_n;
            pbc2  <= pbc_n;
            pd2   <= pd_n;
        end
    end

    // Sum of the three partial products; cannot overflow OW bits.
    always_comb begin
        sum_n = '{default: '0};
        for (int g = 0; g < 4; g++) begin
            sum_n[g] = pa2[g] + pbc2[g] + pd2[g];
        end
    end

    // S3: sum registers plus cardinal/flag delay.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v3    <= 1'b0;
            card3 <= 32'd0;
            d3    <= 1'b0;
            p3    <= 1'b0;
            for (int g = 0; g < 4; g++) begin
                sum3[g] <= '0;
            end
        end else if (en) begin
            v3    <= v2;
            card3 <= card2;
            d3    <= d2;
            p3    <= p2;
            sum3  <= sum_n;
        end
    end

    // Interleave cardinal (even) and diagonal (odd) slots.
    always_comb begin
        s_n = '0;
        for (int k = 0; k < 4; k++) begin
            s_n[(2*k)*OW +: OW]   = {card3[8*k +: 8], {FRAC{1'b0}}};
            s_n[(2*k+1)*OW +: OW] = sum3[k];
        end
    end

    // Output register: holds steady while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_o         <= 1'b0;
            s_o             <= '0;
            done_o          <= 1'b0;
            progress_done_o <= 1'b0;
        end else if (en) begin
            valid_o         <= v3;
            s_o             <= s_n;
            done_o          <= d3;
            progress_done_o <= p3;
        end
    end

endmodule

// File: tb/tb_interp_ring8_pipe.sv
`timescale 1ns/1ps
// Bench for interp_ring8_pipe: a main R=2/FRAC=16/bilinear instance plus
// R=1,3,4 bilinear and R=2,4 nearest instances sharing the same stimulus.
module tb_interp_ring8_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, valid_i, ready_i, done_i, progress_done_i;
    logic [31:0]  card_i;
    logic [127:0] diag_i;
    logic         ready_o, valid_o, done_o, progress_done_o;
    logic [191:0] s_o;
    logic [191:0] so_x [5];
    logic         vo_x [5];
    logic         ro_x [5];
    logic         do_x [5];
    logic         po_x [5];

    interp_ring8_pipe #(.R(2), .FRAC(16), .MODE(1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .card_i(card_i), .diag_i(diag_i), .done_i(done_i),
        .progress_done_i(progress_done_i), .s_o(s_o), .valid_o(valid_o),
        .ready_i(ready_i), .done_o(done_o), .progress_done_o(progress_done_o)
    );

    localparam int RS [5] = '{1, 3, 4, 2, 4};
    localparam int MS [5] = '{1, 1, 1, 0, 0};

    for (genvar i = 0; i < 5; i++) begin : g_x
        interp_ring8_pipe #(.R(RS[i]), .FRAC(16), .MODE(MS[i])) u_x (
            .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ro_x[i]),
            .card_i(card_i), .diag_i(diag_i), .done_i(done_i),
            .progress_done_i(progress_done_i), .s_o(so_x[i]), .valid_o(vo_x[i]),
            .ready_i(ready_i), .done_o(do_x[i]), .progress_done_o(po_x[i])
        );
    end

    typedef struct {
        logic [5:0][191:0] s;
        logic              dn;
        logic              pd;
        int                acc;
        bit                lat;
    } exp_t;

    typedef struct {
        logic [31:0]       c;
        logic [127:0]      d;
        logic [5:0][191:0] s;
    } vec_t;

    exp_t sb [$];
    vec_t tv [4];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   st_base = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [191:0] mk(input logic [23:0] s0, s1, s2, s3, s4, s5, s6, s7);
        return {s7, s6, s5, s4, s3, s2, s1, s0};
    endfunction

    function automatic int wt(input int r, input int j);
        int t [4][3] = '{'{5622, 13573, 32768}, '{22488, 15902, 11244},
                         '{50599, 6986, 965},   '{1929, 9315, 44977}};
        return t[r-1][j];
    endfunction

    // Expected ring for each instance: main, R1, R3, R4, R2-nearest, R4-nearest.
    function automatic logic [5:0][191:0] model_all(input logic [31:0] c, input logic [127:0] d);
        int rr [6] = '{2, 1, 3, 4, 2, 4};
        int mm [6] = '{1, 1, 1, 1, 0, 0};
        logic [5:0][191:0] r;
        int a, b, cc, dd, v;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) begin
                a  = int'(d[32*k +: 8]);
                b  = int'(d[32*k+8 +: 8]);
                cc = int'(d[32*k+16 +: 8]);
                dd = int'(d[32*k+24 +: 8]);
                if (mm[i] == 1)
                    v = wt(rr[i], 0) * a + wt(rr[i], 1) * (b + cc) + wt(rr[i], 2) * dd;
                else
                    v = ((rr[i] == 1 || rr[i] == 4) ? dd : a) * 65536;
                r[i][(2*k)*24 +: 24]   = {c[8*k +: 8], 16'h0000};
                r[i][(2*k+1)*24 +: 24] = 24'(v);
            end
        end
        return r;
    endfunction

    // Ready driver: 0 = always ready, 1 = random, 2 = low for stream cycles 4..7.
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: ready_i = 1'($urandom_range(0, 1));
                2: ready_i = !((cyc - st_base) >= 4 && (cyc - st_base) <= 7);
                default: ready_i = 1'b1;
            endcase
        end
    end

    // Output monitor / scoreboard, sampled on the falling edge.
    logic [191:0] prev_s;
    logic [1:0]   prev_f;
    bit           prev_stall = 1'b0;
    exp_t         me;
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                chk("stall_hold_s", s_o, prev_s);
                chk("stall_hold_flags", 192'({done_o, progress_done_o}), 192'(prev_f));
                chk("stall_hold_valid", 192'(valid_o), 192'd1);
            end
            if (valid_o === 1'b1 && ready_i === 1'b0)
                chk("ready_o_stalled", 192'(ready_o), 192'd0);
            if (valid_o === 1'b0) begin
                chk("ready_o_idle", 192'(ready_o), 192'd1);
                chk("flags_idle", 192'({done_o, progress_done_o}), 192'd0);
            end
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 192'(valid_o), 192'd0);
                end else begin
                    me = sb.pop_front();
                    chk("s_main", s_o, me.s[0]);
                    for (int k = 0; k < 5; k++)
                        chk($sformatf("s_x%0d", k), so_x[k], me.s[k+1]);
                    chk("valid_x", 192'({vo_x[4], vo_x[3], vo_x[2], vo_x[1], vo_x[0]}), 192'd31);
                    chk("done_o", 192'(done_o), 192'(me.dn));
                    chk("progress_done_o", 192'(progress_done_o), 192'(me.pd));
                    if (me.lat)
                        chk("latency", 192'(cyc - me.acc), 192'd3);
                end
            end
            prev_stall = (valid_o === 1'b1 && ready_i === 1'b0);
            prev_s     = s_o;
            prev_f     = {done_o, progress_done_o};
        end
    end

    // Present one beat and hold it until accepted; called at posedge+1.
    task automatic send(input logic [31:0] c, input logic [127:0] d, input logic dn,
                        input logic pd, input exp_t e, output int acc_at);
        bit acc;
        acc = 1'b0;
        acc_at = -1;
        valid_i = 1'b1;
        card_i = c;
        diag_i = d;
        done_i = dn;
        progress_done_i = pd;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = ready_o;
            e.acc = cyc + 1;
            @(posedge clk);
            if (acc) begin
                sb.push_back(e);
                acc_at = e.acc;
            end
            #1;
        end
        if (!acc) chk("accept_timeout", 192'(acc), 192'd1);
    endtask

    // Idle cycles with junk on the data/flag inputs, which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid_i = 1'b0;
            card_i = $urandom;
            diag_i = {$urandom, $urandom, $urandom, $urandom};
            done_i = 1'b1;
            progress_done_i = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && sb.size() != 0; t++) idle(1);
        chk("drain_empty", 192'(sb.size()), 192'd0);
        idle(2);
    endtask

    initial begin
        logic [23:0] z;
        logic [23:0] f;
        logic [31:0] c;
        logic [127:0] d;
        exp_t e;
        int acc_at, rst_edge;

        z = 24'h000000;
        f = 24'h640000;
        tv[0].c = 32'h64646464;
        tv[0].d = {16{8'h64}};
        for (int i = 0; i < 6; i++) tv[0].s[i] = mk(f, f, f, f, f, f, f, f);
        tv[1].c = 32'h0;
        tv[1].d = 128'h00000000_00000000_00000000_FF000000;
        tv[1].s[0] = mk(z, 24'h2BC014, z, z, z, z, z, z);
        tv[1].s[1] = mk(z, 24'h7F8000, z, z, z, z, z, z);
        tv[1].s[2] = mk(z, 24'h03C13B, z, z, z, z, z, z);
        tv[1].s[3] = mk(z, 24'hAF014F, z, z, z, z, z, z);
        tv[1].s[4] = mk(z, z, z, z, z, z, z, z);
        tv[1].s[5] = mk(z, 24'hFF0000, z, z, z, z, z, z);
        tv[2].c = 32'h0;
        tv[2].d = 128'h00000000_00000000_C800000A_00000000;
        tv[2].s[0] = mk(z, z, z, 24'h25BED0, z, z, z, z);
        tv[2].s[1] = mk(z, z, z, 24'h64DB9C, z, z, z, z);
        tv[2].s[2] = mk(z, z, z, 24'h0AAA6E, z, z, z, z);
        tv[2].s[3] = mk(z, z, z, 24'h898DA2, z, z, z, z);
        tv[2].s[4] = mk(z, z, z, 24'h0A0000, z, z, z, z);
        tv[2].s[5] = mk(z, z, z, 24'hC80000, z, z, z, z);
        tv[3].c = 32'h04030201;
        tv[3].d = 128'h00000000_00010100_00000000_00000000;
        tv[3].s[0] = mk(24'h010000, z, 24'h020000, z, 24'h030000, 24'h007C3C, 24'h040000, z);
        tv[3].s[1] = mk(24'h010000, z, 24'h020000, z, 24'h030000, 24'h006A0A, 24'h040000, z);
        tv[3].s[2] = mk(24'h010000, z, 24'h020000, z, 24'h030000, 24'h003694, 24'h040000, z);
        tv[3].s[3] = mk(24'h010000, z, 24'h020000, z, 24'h030000, 24'h0048C6, 24'h040000, z);
        tv[3].s[4] = mk(24'h010000, z, 24'h020000, z, 24'h030000, z, 24'h040000, z);
        tv[3].s[5] = mk(24'h010000, z, 24'h020000, z, 24'h030000, z, 24'h040000, z);

        rst = 1'b0;
        valid_i = 1'b0;
        card_i = 32'h0;
        diag_i = 128'h0;
        done_i = 1'b0;
        progress_done_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid_o", 192'(valid_o), 192'd0);
        chk("rst_s_o", s_o, 192'd0);
        chk("rst_flags", 192'({done_o, progress_done_o}), 192'd0);
        for (int k = 0; k < 5; k++) chk($sformatf("rst_s_x%0d", k), so_x[k], 192'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 192'(ready_o), 192'd1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors: one isolated beat each, exact latency expected.
        for (int i = 0; i < 4; i++) begin
            e.s = tv[i].s;
            e.dn = 1'b0;
            e.pd = 1'b0;
            e.lat = 1'b1;
            send(tv[i].c, tv[i].d, 1'b0, 1'b0, e, acc_at);
            drain();
        end

        // Back-pressure: six counting beats, ready_i low for stream cycles 4..7.
        rdy_mode = 2;
        st_base = cyc;
        for (int i = 0; i < 6; i++) begin
            c = 32'h03020100 + 32'h04040404 * 32'(i);
            d = 128'h1F1E1D1C_1B1A1918_17161514_13121110 + {4{32'h01010101}} * 128'(i);
            e.s = model_all(c, d);
            e.dn = 1'b0;
            e.pd = 1'b0;
            e.lat = 1'b0;
            send(c, d, 1'b0, 1'b0, e, acc_at);
        end
        drain();

        // Flags under random back-pressure: done on beat 5, progress on beat 2.
        rdy_mode = 1;
        for (int i = 1; i <= 8; i++) begin
            c = $urandom;
            d = {$urandom, $urandom, $urandom, $urandom};
            e.s = model_all(c, d);
            e.dn = (i == 5);
            e.pd = (i == 2);
            e.lat = 1'b0;
            send(c, d, e.dn, e.pd, e, acc_at);
        end
        drain();
        rdy_mode = 0;
        idle(2);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            c = $urandom;
            d = {$urandom, $urandom, $urandom, $urandom};
            e.s = model_all(c, d);
            e.dn = 1'b1;
            e.pd = 1'b1;
            e.lat = 1'b1;
            send(c, d, 1'b1, 1'b1, e, acc_at);
        end
        valid_i = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        rst_edge = cyc;
        sb.delete();
        #3;
        chk("midrst_valid_o", 192'(valid_o), 192'd0);
        chk("midrst_s_o", s_o, 192'd0);
        chk("midrst_flags", 192'({done_o, progress_done_o}), 192'd0);
        for (int k = 0; k < 5; k++) chk($sformatf("midrst_s_x%0d", k), so_x[k], 192'd0);
        c = 32'hA5C3_7E11;
        d = 128'h0102_0304_1122_3344_5566_7788_99AA_BBCC;
        e.s = model_all(c, d);
        e.dn = 1'b1;
        e.pd = 1'b0;
        e.lat = 1'b1;
        send(c, d, 1'b1, 1'b0, e, acc_at);
        chk("accept_after_rst", 192'(acc_at), 192'(rst_edge + 1));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/interp_ring8_pipe.md
# interp_ring8_pipe

Parametrised successor to the 8-neighbour circular sampling interpolator in the LBP feature path. For each accepted pixel beat it takes four cardinal samples and four 2×2 corner groups for the diagonals at radius R. It emits eight fixed-point ring samples in 8.FRAC format. It adds a valid/ready handshake with full-pipeline stall, beat-aligned sideband flags, a selectable fractional width, and a nearest-neighbour mode.

## Interface
- R, default 2: sampling radius, legal 1..4 (elaboration error otherwise).
- FRAC, default 16: output fractional bits, legal 8..16.
- MODE, default 1: 1 = bilinear diagonals, 0 = nearest-neighbour diagonals.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- valid_i  in  1  input beat valid.
- ready_o  out  1  block can accept a beat this cycle.
- card_i  in  32  cardinal samples, bytes [7:0]=0°, [15:8]=90°, [23:16]=180°, [31:24]=270°.
- diag_i  in  128  diagonal corners; 32-bit group g (0=45°, 1=135°, 2=225°, 3=315°) holds bytes A,B,C,D at offsets 0,8,16,24. A is the corner nearest the centre, D the farthest, B/C mixed.
- done_i  in  1  frame-done flag, travels with the beat.
- progress_done_i  in  1  progress flag, travels with the beat.
- s_o  out  8*(8+FRAC)  ring samples, slot k holds direction k×45°, each 8.FRAC unsigned.
- valid_o  out  1  s_o and flags valid.
- ready_i  in  1  downstream accepts.
- done_o, progress_done_o  out  1  each  flags of the beat currently on s_o.

## Operation
- Three-stage pipeline: S1 registers inputs; S2 forms weighted products; S3 sums and registers outputs.
- Global advance enable en = ready_i | ~valid_o. ready_o = en (combinational).
- A beat is accepted when valid_i & ready_o. Per-stage valid bits shift on en.
- Cardinal slots (0,2,4,6) output {sample, FRAC zeros}, delayed through all three stages.
- Diagonal bilinear: out = wA·A + wBC·(B+C) + wD·D.
  - The weights are elaboration constants, and wA+2·wBC+wD = 2^FRAC exactly.
  - The result is therefore exact, fits 8+FRAC bits, and needs no rounding or saturation.
- Weights at FRAC=16 (wA/wBC/wD):
  - R=1: 5622/13573/32768
  - R=2: 22488/15902/11244
  - R=3: 50599/6986/965
  - R=4: 1929/9315/44977
- For FRAC<16, wBC and wD = round(w16 / 2^(16−FRAC)). wA = 2^FRAC − 2·wBC − wD.
- MODE=0: a diagonal slot outputs {A, FRAC zeros} if wD < 2^(FRAC−1), else {D, FRAC zeros}. This selects A for R=2,3 and D for R=1,4. Latency is unchanged.
- done_i and progress_done_i are captured only on acceptance and emerge with the same beat's output. They are never asserted while valid_o=0.
- Input values and flags are ignored when not accepted. Holding valid_i high with changing data is legal; only the accepted sample counts.

## Timing
- Latency: an accepted beat at edge n appears with valid_o=1 after edge n+3, provided en stays high throughout.
- Throughput: one beat per cycle while ready_i=1.
- Stall: ready_i=0 with valid_o=1 freezes all stages. s_o, valid_o and the flags hold stable, and ready_o=0.
- Bubbles: empty stages collapse only through the output slot (~valid_o). No partial-stage compaction is required.
- Reset (rst=0 at an edge) clears every stage valid bit, s_o, done_o and progress_done_o to 0. valid_o=0, and ready_o=1 in the cycle after reset.
- Reset mid-stream discards all in-flight beats; no output emerges for them.
- Simultaneous accept and output handshake in one cycle is legal and loses nothing.

## Test plan
- Flat field: R=2, FRAC=16, all 20 bytes = 100, one beat. Required: all eight slots = 0x640000 at edge n+3, valid_o pulses 1 cycle. Repeat for R=1,3,4 with the same result.
- Single corner: R=2, MODE=1, 45° group A=B=C=0, D=255, cardinals 0. Required: slot1 = 0x2BC014, all other slots 0.
- Nearest mode: R=2, MODE=0, 135° group A=10, D=200. Required: slot3 = 0x0A0000. With R=4 the same input requires 0xC80000.
- Back-pressure: stream 6 beats with a counting pattern, ready_i low for cycles 4–7. Required: no beat lost or duplicated, order preserved, s_o stable during the stall, ready_o=0 while stalled and full.
- Flags: done_i=1 on beat 5 only and progress_done_i=1 on beat 2 only, under random ready_i. Required: done_o and progress_done_o are asserted exactly with output beats 5 and 2.
- Reset mid-stream: rst=0 for one cycle with 3 beats in flight. Required: all outputs 0 on the next cycle, none of those beats emerge, and a new beat is accepted in the cycle after rst returns to 1.
